// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : branch_redirect_ctrl
//  Purpose  : Sequences EX-stage control-flow changes. Combines the branch
//             unit's taken decision with JAL/JALR decode, requests a PC
//             redirect from fetch over valid/ready, stalls EX until the
//             redirect is accepted, then flushes IF/ID for FLUSH_CYCLES
//             cycles. Counts accepted redirects (saturating).
//  Ports    : clk_in, rst_n_in          - clock, async active-low reset
//             ex_valid_in               - EX holds a valid instruction
//             opcode_6_to_2_in[4:0]     - opcode[6:2] of the EX instruction
//             branch_taken_in           - branch unit result
//             target_pc_in[XLEN-1:0]    - computed branch/jump target
//             redirect_ready_in         - fetch accepts the redirect
//             redirect_valid_out        - redirect request pending
//             redirect_pc_out[XLEN-1:0] - registered redirect target
//             stall_out                 - hold EX and earlier stages
//             flush_out                 - squash IF/ID contents
//             misaligned_out            - 1-cycle pulse, target not aligned
//             redirect_count_out[15:0]  - saturating accepted-redirect count
//  Revision : 1.0 - initial release
// ============================================================================
module branch_redirect_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = 32
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            ex_valid_in,
    input  logic [4:0]      opcode_6_to_2_in,
    input  logic            branch_taken_in,
    input  logic [XLEN-1:0] target_pc_in,
    input  logic            redirect_ready_in,
    output logic            redirect_valid_out,
    output logic [XLEN-1:0] redirect_pc_out,
    output logic            stall_out,
    output logic            flush_out,
    output logic            misaligned_out,
    output logic [15:0]     redirect_count_out
);

    localparam logic [4:0]  c_OP_BRANCH  = 5'b11000;
    localparam logic [4:0]  c_OP_JALR    = 5'b11001;
    localparam logic [4:0]  c_OP_JAL     = 5'b11011;
    localparam logic [3:0]  c_FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam logic [15:0] c_COUNT_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [3:0]      r_flush_cnt;
    logic [3:0]      w_flush_cnt_next;
    logic [XLEN-1:0] r_redirect_pc;
    logic [XLEN-1:0] w_redirect_pc_next;
    logic [15:0]     r_count;
    logic            r_valid;
    logic            r_stall;
    logic            r_flush;
    logic            r_misaligned;
    logic            w_valid_next;
    logic            w_stall_next;
    logic            w_flush_next;
    logic            w_misaligned_next;
    logic            w_accept;

    logic            w_is_branch;
    logic            w_is_jal;
    logic            w_is_jalr;
    logic            w_redirect_req;
    logic [XLEN-1:0] w_eff_target;

    // Decode and effective target. JALR drops bit 0 of the target; any
    // remaining bit 1 means the target is not 4-byte aligned.
    always_comb begin
        w_is_branch    = (opcode_6_to_2_in == c_OP_BRANCH);
        w_is_jal       = (opcode_6_to_2_in == c_OP_JAL);
        w_is_jalr      = (opcode_6_to_2_in == c_OP_JALR);
        w_redirect_req = ex_valid_in &&
                         ((w_is_branch && branch_taken_in) || w_is_jal || w_is_jalr);
        w_eff_target   = target_pc_in;
        if (w_is_jalr) begin
            w_eff_target[0] = 1'b0;
        end
    end

    // Next-state and next-output logic. Every output is the registered
    // version of these next values, so inputs never reach outputs directly.
    always_comb begin
        w_state_next       = r_state;
        w_flush_cnt_next   = r_flush_cnt;
        w_redirect_pc_next = r_redirect_pc;
        w_valid_next       = 1'b0;
        w_stall_next       = 1'b0;
        w_flush_next       = 1'b0;
        w_misaligned_next  = 1'b0;
        w_accept           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_redirect_req) begin
                    if (w_eff_target[1]) begin
                        w_misaligned_next = 1'b1;
                    end else begin
                        w_redirect_pc_next = w_eff_target;
                        w_state_next       = ST_REQ;
                        w_valid_next       = 1'b1;
                        w_stall_next       = 1'b1;
                        w_flush_next       = 1'b1;
                    end
                end
            end

            ST_REQ: begin
                if (redirect_ready_in) begin
                    w_accept         = 1'b1;
                    w_state_next     = ST_FLUSH;
                    w_flush_cnt_next = c_FLUSH_LOAD;
                    w_flush_next     = 1'b1;
                end else begin
                    w_valid_next = 1'b1;
                    w_stall_next = 1'b1;
                    w_flush_next = 1'b1;
                end
            end

            ST_FLUSH: begin
                // The counter holds the number of FLUSH cycles still to run,
                // including the current one; leave on the edge where it is 1.
                if (r_flush_cnt <= 4'd1) begin
                    w_flush_cnt_next = 4'd0;
                    w_state_next     = ST_IDLE;
                end else begin
                    w_flush_cnt_next = r_flush_cnt - 4'd1;
                    w_flush_next     = 1'b1;
                end
            end

            default: begin
                w_state_next     = ST_IDLE;
                w_flush_cnt_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_flush_cnt   <= 4'd0;
            r_redirect_pc <= '0;
            r_valid       <= 1'b0;
            r_stall       <= 1'b0;
            r_flush       <= 1'b0;
            r_misaligned  <= 1'b0;
        end else begin
            r_flush_cnt   <= w_flush_cnt_next;
            r_redirect_pc <= w_redirect_pc_next;
            r_valid       <= w_valid_next;
            r_stall       <= w_stall_next;
            r_flush       <= w_flush_next;
            r_misaligned  <= w_misaligned_next;
        end
    end

    // Count only moves on an acceptance below the saturation value.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_count <= 16'd0;
        end else if (w_accept && (r_count != c_COUNT_MAX)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign redirect_valid_out = r_valid;
    assign redirect_pc_out    = r_redirect_pc;
    assign stall_out          = r_stall;
    assign flush_out          = r_flush;
    assign misaligned_out     = r_misaligned;
    assign redirect_count_out = r_count;

endmodule
`default_nettype wire

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequences control-flow changes resolved in EX. It combines the branch unit's `branch_taken` decision with JAL/JALR opcode decode, requests a PC redirect from fetch over a valid/ready handshake, and stalls EX until the redirect is accepted. It then flushes IF/ID for a programmable number of cycles and counts completed redirects. It sits between the EX-stage branch unit and the fetch/PC logic.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: cycles `flush_out` stays high after redirect acceptance. Legal range 1..15.
- `XLEN`, default 32: PC width.

Ports:
- `clk_in`  in  1  single clock; all state updates on the rising edge.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `ex_valid_in`  in  1  EX stage holds a valid instruction.
- `opcode_6_to_2_in`  in  5  opcode[6:2] of the EX instruction.
- `branch_taken_in`  in  1  branch unit result for the EX instruction.
- `target_pc_in`  in  XLEN  computed branch/jump target.
- `redirect_ready_in`  in  1  fetch accepts the redirect.
- `redirect_valid_out`  out  1  redirect request pending.
- `redirect_pc_out`  out  XLEN  registered redirect target.
- `stall_out`  out  1  hold EX and earlier stages.
- `flush_out`  out  1  squash IF/ID contents.
- `misaligned_out`  out  1  one-cycle pulse: target not 4-byte aligned.
- `redirect_count_out`  out  16  saturating count of accepted redirects.

## Operation
Decode on `opcode_6_to_2_in`:
- BRANCH = 5'b11000
- JALR = 5'b11001
- JAL = 5'b11011

Redirect condition (evaluated only in IDLE): `ex_valid_in` and ((BRANCH and `branch_taken_in`) or JAL or JALR).

Effective target:
- JALR: `target_pc_in` with bit 0 cleared.
- Otherwise: `target_pc_in` unchanged.
- If bit 1 of the effective target is set, the target is misaligned. The block pulses `misaligned_out` for one cycle, makes no redirect, and stays in IDLE.

FSM, 3 states:
- **IDLE**
  - On an aligned redirect condition: register the target into `redirect_pc_out` and go to REQ.
  - Otherwise: stay in IDLE.
- **REQ**
  - `redirect_valid_out`=1, `stall_out`=1, `flush_out`=1.
  - `redirect_pc_out` holds stable until accepted.
  - On `redirect_ready_in`=1 at an edge: acceptance. Increment `redirect_count_out` (saturates at 16'hFFFF) and go to FLUSH with the flush counter loaded to `FLUSH_CYCLES`.
- **FLUSH**
  - `flush_out`=1, `stall_out`=0, `redirect_valid_out`=0.
  - The counter decrements each cycle.
  - Go to IDLE on the edge where the counter reaches 1.

Other rules:
- EX inputs are ignored outside IDLE. Instructions arriving during REQ are stalled; instructions arriving during FLUSH are squashed.
- `redirect_pc_out` retains its last value after acceptance.
- All outputs are registered. No combinational path exists from inputs to outputs.

Reset values (async, `rst_n_in`=0):
- state = IDLE, all 1-bit outputs = 0.
- `redirect_pc_out` = 0, `redirect_count_out` = 0, flush counter = 0.
- Reset asserted mid-REQ or mid-FLUSH aborts immediately. No acceptance is counted.

## Timing
- Redirect condition true during cycle T → `redirect_valid_out`, `stall_out`, `flush_out` high from cycle T+1.
- `redirect_ready_in` high in cycle T+1 (zero-wait acceptance):
  - REQ lasts exactly 1 cycle.
  - `flush_out` stays high for cycles T+2 .. T+1+`FLUSH_CYCLES`.
  - Total `flush_out` width = 1 + `FLUSH_CYCLES`.
- Each cycle `redirect_ready_in` is low extends REQ, and therefore `stall_out`, by one cycle.
- `redirect_count_out` updates on the acceptance edge, so the new value is visible in the first FLUSH cycle.
- Misaligned target in cycle T → `misaligned_out` high only in cycle T+1.
- Back-to-back: a redirect condition present in the cycle the FSM is already in IDLE is accepted. The earliest next REQ is the cycle after FLUSH ends.

## Test plan
1. BEQ taken: opcode 11000, taken=1, target 0x0000_0100, ready tied 1, `FLUSH_CYCLES`=2.
   → valid 1 cycle with pc 0x100; flush high 3 cycles; stall high 1 cycle; count=1.
2. Branch not taken, plus `ex_valid_in`=0 with JAL opcode.
   → no valid, stall or flush; count stays 0.
3. JAL, target 0x0000_2000, ready held low 3 cycles then high.
   → valid/stall high 4 cycles with pc stable at 0x2000; then 2 flush-only cycles; count=1.
4. JALR with target 0x0000_1001 → redirect pc 0x0000_1000. Then JALR with target 0x0000_1003.
   → second gives a `misaligned_out` 1-cycle pulse, no valid, count unchanged.
5. `rst_n_in` pulsed low mid-REQ (ready low).
   → all outputs 0 asynchronously; FSM in IDLE; count unchanged. A following taken branch redirects normally.
6. Preload to 16'hFFFE via repeated redirects (or force), then 3 accepted redirects.
   → count reads 0xFFFF and holds.
